mda_uart_rx: RTL and testbench
==============================

# mda_uart_rx

Oversampling UART receiver that turns the asynchronous serial line coming back from the IMU into a buffered byte stream. It is the counterpart of the existing Nios UART transmit path. It sits between the IMU receive pin (already gated high by the top level while the kill switch is off) and the control logic or Avalon bridge that consumes IMU frames. It adds start-bit validation, framing and overrun detection, and a small FIFO so software latency does not drop bytes.

## Interface
- CLK_HZ, 50000000: input clock frequency.
- BAUD, 115200: line rate; 8 data bits, 1 stop bit, LSB first.
- FIFO_DEPTH, 16: received-byte buffer depth; must be a power of two, at least 2.

- clk  in  1  system clock (CLOCK_50 at top level).
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  receiver enable; low aborts any frame in progress.
- rxd_in  in  1  asynchronous serial input; idle high.
- rx_data  out  8  FIFO head byte; valid while rx_valid is high.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer pop; a pop occurs on a clock where rx_valid and rx_ready are both high.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun_err  out  1  one-cycle pulse: good byte dropped because FIFO full.
- parity_err  out  1  one-cycle pulse; tied 0 unless parity is compiled in.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  bytes currently buffered.

## Operation
- rxd_in passes through a 2-flop synchronizer; both flops reset to 1.
- Tick generator: DIV = CLK_HZ/(16*BAUD) using integer division, floored to a minimum of 1 (27 at defaults). The counter runs 0..DIV-1 and is cleared on start detection.
- State machine with states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: a synced falling edge clears the tick counter and the sub-bit count, then goes to START.
  - START: at 8 ticks, samples the line. Low → DATA. High → false start → IDLE; nothing is reported.
  - DATA: samples every 16 ticks and shifts bits in LSB first. After bit 7 → STOP, or → PARITY if parity is compiled in.
  - PARITY: samples one bit and checks it; see Configuration.
  - STOP: samples once. High → push the byte → IDLE. Low → frame_err pulse, byte discarded → WAIT_IDLE.
  - WAIT_IDLE: waits for the synced line to read high, then → IDLE. This prevents a break condition from producing repeated frames.
- enable low forces IDLE and discards the partial byte. FIFO contents and fifo_level are kept. While enable is low, no error pulses are generated.
- FIFO push and pop are evaluated in the same cycle:
  - Push when full with no simultaneous pop: the byte is dropped, overrun_err pulses, stored order is unchanged.
  - Push when full with a simultaneous pop: both occur and no overrun is reported.
  - Pop when empty: ignored.
- Reset values: rx_data 0x00, rx_valid 0, all error pulses 0, fifo_level 0, state IDLE.
- Reset asserted mid-frame: the partial byte is lost and FIFO contents are cleared.

## Timing
- Start detection occurs 2 clocks after the rxd_in falling edge (synchronizer delay).
- The stop sample is taken 8+16*9 ticks after detection, or 8+16*10 ticks with parity.
- Push happens on the clock after the stop sample. rx_valid and rx_data update on the clock after the push.
- Pop with FIFO_LEVEL > 1: the next byte appears on rx_data on the following clock, with rx_valid staying high.
- Error pulses are exactly one clock wide, asserted on the clock after the offending sample.

## Configuration
- MDA_UART_RX_PARITY_EN defined: a parity bit is received after the data bits.
  - Parameter ODD_PARITY, default 0, selects even or odd parity.
  - On mismatch, parity_err pulses and the byte is still pushed, so software can discard it.
- Macro undefined: there is no PARITY state, parity_err is constant 0, and frames are 10 bits long.

## Structure
- Package mda_uart_pkg holds:
  - the state enum;
  - OVERSAMPLE = 16;
  - MID_SAMPLE = 8;
  - the divisor function shared with any future UART transmitter.
- One sub-module: mda_sync_fifo. It is a parameterised width/depth FIFO with a registered head, level output, and the simultaneous push/pop-when-full rule above.

## Test plan
- Send 0x55, then 0xA3, at 115200 with rx_ready=1 → rx_data shows 0x55 then 0xA3, each with a single-cycle rx_valid; no error pulses.
- Send a frame of 0x3C with the stop bit held low, followed by 2 bit-times of low → exactly one frame_err pulse, no push, and a following 0x7E is received correctly.
- Hold rx_ready=0 and send 17 bytes 0x00..0x10 → fifo_level reaches 16 and exactly one overrun_err pulse occurs. Draining then yields 0x00..0x0F in order.
- Apply a 4-tick low glitch on an idle line → no push, no errors, state returns to IDLE.
- Assert reset_n low during bit 4 of a frame while 3 bytes are buffered → rx_valid=0, fifo_level=0; the next 0x99 is received correctly.
- With MDA_UART_RX_PARITY_EN and even parity, send 0x01 with the parity bit set to 0 → parity_err pulse and 0x01 is pushed; with parity bit 1 → no error.

Source files
------------

// File: rtl/mda_uart_pkg.sv
// Shared definitions for the IMU UART receive path: FSM states, oversampling
// constants and the baud divisor helper. Optional parity: MDA_UART_RX_PARITY_EN.
package mda_uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef MDA_UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_t;

  // Clocks per oversample tick, never below 1.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    int unsigned d;
    d = clk_hz / (OVERSAMPLE * baud);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/mda_sync_fifo.sv
// Synchronous FIFO with registered head, level output and overrun pulse.
// A push while full is accepted only when a pop happens in the same cycle.
module mda_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overrun
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_next;
  logic [AW:0]      remain;
  logic             do_push, do_pop, full;

  always_comb begin
    do_pop  = pop && (level != '0);
    full    = (level == (AW+1)'(DEPTH));
    do_push = push && (!full || do_pop);
    rd_next = rd_ptr + AW'(do_pop);
    remain  = level - (AW+1)'(do_pop);
  end

  assign valid = (level != '0);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Head is refreshed from the slot that will be at the front after this
  // cycle; when that slot is being written right now, take the input directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      head    <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push && !do_push;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_next;
      level  <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
      if (remain != '0) head <= mem[rd_next];
      else if (do_push) head <= push_data;
    end
  end

endmodule

// File: rtl/mda_uart_rx.sv
// Oversampling 8N1 UART receiver for the IMU link with a byte FIFO.
// Define MDA_UART_RX_PARITY_EN to receive and check a parity bit.
module mda_uart_rx
  import mda_uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16
`ifdef MDA_UART_RX_PARITY_EN
  ,parameter bit         ODD_PARITY = 1'b0
`endif
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          rxd_in,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          overrun_err,
  output logic                          parity_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned DIV   = baud_div(CLK_HZ, BAUD);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  rx_state_t        state;
  logic             sync1, rx_s, rx_prev;
  logic [DIV_W-1:0] tick_cnt;
  logic [3:0]       os_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             push;
  logic [7:0]       push_data;
  logic             tick, fall;

  assign tick = (tick_cnt == DIV_W'(DIV - 1));
  assign fall = rx_prev && !rx_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rxd_in;
      rx_s  <= sync1;
    end
  end

`ifdef MDA_UART_RX_PARITY_EN
  logic parity_err_r;
  assign parity_err = parity_err_r;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      rx_prev   <= 1'b1;
      tick_cnt  <= '0;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      push      <= 1'b0;
      push_data <= '0;
      frame_err <= 1'b0;
`ifdef MDA_UART_RX_PARITY_EN
      parity_err_r <= 1'b0;
`endif
    end else begin
      rx_prev   <= rx_s;
      push      <= 1'b0;
      frame_err <= 1'b0;
`ifdef MDA_UART_RX_PARITY_EN
      parity_err_r <= 1'b0;
`endif
      if (state == ST_IDLE && enable && fall) tick_cnt <= '0;
      else if (tick)                          tick_cnt <= '0;
      else                                    tick_cnt <= tick_cnt + DIV_W'(1);

      if (!enable) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (fall) begin
            os_cnt <= '0;
            state  <= ST_START;
          end
          ST_START: if (tick) begin
            if (os_cnt == 4'(MID_SAMPLE - 1)) begin
              os_cnt  <= '0;
              bit_cnt <= '0;
              state   <= rx_s ? ST_IDLE : ST_DATA;
            end else os_cnt <= os_cnt + 4'd1;
          end
          ST_DATA: if (tick) begin
            if (os_cnt == 4'(OVERSAMPLE - 1)) begin
              os_cnt  <= '0;
              shreg   <= {rx_s, shreg[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
`ifdef MDA_UART_RX_PARITY_EN
              if (bit_cnt == 3'd7) state <= ST_PARITY;
`else
              if (bit_cnt == 3'd7) state <= ST_STOP;
`endif
            end else os_cnt <= os_cnt + 4'd1;
          end
`ifdef MDA_UART_RX_PARITY_EN
          ST_PARITY: if (tick) begin
            if (os_cnt == 4'(OVERSAMPLE - 1)) begin
              os_cnt       <= '0;
              parity_err_r <= ((^shreg) ^ rx_s) != ODD_PARITY;
              state        <= ST_STOP;
            end else os_cnt <= os_cnt + 4'd1;
          end
`endif
          ST_STOP: if (tick) begin
            if (os_cnt == 4'(OVERSAMPLE - 1)) begin
              os_cnt <= '0;
              if (rx_s) begin
                push      <= 1'b1;
                push_data <= shreg;
                state     <= ST_IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= ST_WAIT_IDLE;
              end
            end else os_cnt <= os_cnt + 4'd1;
          end
          ST_WAIT_IDLE: if (rx_s) state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  mda_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (rx_ready),
    .head      (rx_data),
    .valid     (rx_valid),
    .level     (fifo_level),
    .overrun   (overrun_err)
  );

endmodule

// File: tb/tb_mda_uart_rx.sv
// Directed bench for mda_uart_rx at 4 clocks per oversample tick (64 clocks/bit).
// Parity steps are included when MDA_UART_RX_PARITY_EN is defined.
module tb_mda_uart_rx;
  import mda_uart_pkg::*;

  localparam int unsigned BAUD   = 115200;
  localparam int unsigned CLK_HZ = 16 * 4 * BAUD;
  localparam int unsigned BIT    = 64;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b1;
  logic       rxd_in = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun_err, parity_err;
  logic [4:0] fifo_level;

  int checks = 0;
  int errors = 0;

  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, valid_cycles = 0;
  logic [7:0] popped[$];

  int fe0, ov0, pe0, vc0, pop0;

  mda_uart_rx #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .rxd_in      (rxd_in),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err)   fe_cnt++;
    if (overrun_err) ov_cnt++;
    if (parity_err)  pe_cnt++;
    if (rx_valid)    valid_cycles++;
    if (rx_valid && rx_ready) popped.push_back(rx_data);
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    rxd_in = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 8; i++) begin
      rxd_in = d[i];
      wait_clks(BIT);
    end
`ifdef MDA_UART_RX_PARITY_EN
    rxd_in = par;
    wait_clks(BIT);
`else
    if (par) rxd_in = 1'b1;
`endif
    rxd_in = stop;
    wait_clks(BIT);
    rxd_in = 1'b1;
  endtask

  // Correct even-parity bit for a byte (ignored when parity is not compiled in).
  function automatic logic epar(input logic [7:0] d);
    return ^d;
  endfunction

  task automatic snap();
    fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt; vc0 = valid_cycles; pop0 = popped.size();
  endtask

  initial begin
    // Reset state
    wait_clks(5);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_fifo_level", 32'(fifo_level), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_overrun_err", 32'(overrun_err), 32'd0);
    check("reset_parity_err", 32'(parity_err), 32'd0);
    reset_n = 1'b1;
    wait_clks(BIT);

    // Two good bytes with the consumer always ready
    rx_ready = 1'b1;
    snap();
    send_frame(8'h55, epar(8'h55), 1'b1);
    wait_clks(BIT);
    send_frame(8'hA3, epar(8'hA3), 1'b1);
    wait_clks(BIT);
    check("good_pop_count", 32'(popped.size() - pop0), 32'd2);
    if (popped.size() - pop0 == 2) begin
      check("good_byte0", 32'(popped[pop0]), 32'h55);
      check("good_byte1", 32'(popped[pop0 + 1]), 32'hA3);
    end
    check("good_valid_cycles", 32'(valid_cycles - vc0), 32'd2);
    check("good_no_errors", 32'(fe_cnt - fe0 + ov_cnt - ov0 + pe_cnt - pe0), 32'd0);

    // Framing error followed by a break of two bit times, then a good byte
    snap();
    send_frame(8'h3C, epar(8'h3C), 1'b0);
    rxd_in = 1'b0;
    wait_clks(2 * BIT);
    rxd_in = 1'b1;
    wait_clks(BIT);
    check("frame_err_pulses", 32'(fe_cnt - fe0), 32'd1);
    check("frame_err_no_push", 32'(popped.size() - pop0), 32'd0);
    send_frame(8'h7E, epar(8'h7E), 1'b1);
    wait_clks(BIT);
    check("after_frame_pop_count", 32'(popped.size() - pop0), 32'd1);
    if (popped.size() - pop0 == 1) check("after_frame_byte", 32'(popped[pop0]), 32'h7E);
    check("after_frame_err_total", 32'(fe_cnt - fe0), 32'd1);

    // Short glitch on an idle line
    snap();
    rxd_in = 1'b0;
    wait_clks(16);
    rxd_in = 1'b1;
    wait_clks(2 * BIT);
    check("glitch_no_push", 32'(popped.size() - pop0), 32'd0);
    check("glitch_no_errors", 32'(fe_cnt - fe0 + ov_cnt - ov0 + pe_cnt - pe0), 32'd0);
    check("glitch_state_idle", 32'(dut.state), 32'(ST_IDLE));
    check("glitch_level", 32'(fifo_level), 32'd0);

    // Fill past capacity with the consumer stalled
    rx_ready = 1'b0;
    snap();
    for (int b = 0; b <= 16; b++) begin
      send_frame(8'(b), epar(8'(b)), 1'b1);
      wait_clks(8);
    end
    wait_clks(BIT);
    check("full_level", 32'(fifo_level), 32'd16);
    check("full_overrun_pulses", 32'(ov_cnt - ov0), 32'd1);
    check("full_head", 32'(rx_data), 32'h00);
    rx_ready = 1'b1;
    wait_clks(40);
    check("drain_count", 32'(popped.size() - pop0), 32'd16);
    if (popped.size() - pop0 == 16)
      for (int b = 0; b < 16; b++) check($sformatf("drain_byte%0d", b), 32'(popped[pop0 + b]), 32'(b));
    check("drain_level", 32'(fifo_level), 32'd0);

    // Reset during bit 4 of a frame while three bytes are buffered
    rx_ready = 1'b0;
    send_frame(8'h11, epar(8'h11), 1'b1);
    wait_clks(8);
    send_frame(8'h22, epar(8'h22), 1'b1);
    wait_clks(8);
    send_frame(8'h33, epar(8'h33), 1'b1);
    wait_clks(BIT);
    check("pre_reset_level", 32'(fifo_level), 32'd3);
    rxd_in = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 4; i++) begin
      rxd_in = i[0];
      wait_clks(BIT);
    end
    rxd_in = 1'b1;
    wait_clks(BIT / 2);
    reset_n = 1'b0;
    wait_clks(4);
    check("midreset_valid", 32'(rx_valid), 32'd0);
    check("midreset_level", 32'(fifo_level), 32'd0);
    reset_n = 1'b1;
    wait_clks(2 * BIT);
    check("postreset_level", 32'(fifo_level), 32'd0);
    send_frame(8'h99, epar(8'h99), 1'b1);
    wait_clks(BIT);
    check("postreset_99_valid", 32'(rx_valid), 32'd1);
    check("postreset_99_data", 32'(rx_data), 32'h99);
    check("postreset_99_level", 32'(fifo_level), 32'd1);
    rx_ready = 1'b1;
    wait_clks(4);
    rx_ready = 1'b0;
    check("postreset_drained", 32'(fifo_level), 32'd0);

`ifdef MDA_UART_RX_PARITY_EN
    // Even parity: 0x01 needs parity bit 1
    rx_ready = 1'b1;
    snap();
    send_frame(8'h01, 1'b0, 1'b1);
    wait_clks(BIT);
    check("parity_bad_pulse", 32'(pe_cnt - pe0), 32'd1);
    check("parity_bad_pushed", 32'(popped.size() - pop0), 32'd1);
    if (popped.size() - pop0 == 1) check("parity_bad_byte", 32'(popped[pop0]), 32'h01);
    snap();
    send_frame(8'h01, 1'b1, 1'b1);
    wait_clks(BIT);
    check("parity_good_no_pulse", 32'(pe_cnt - pe0), 32'd0);
    check("parity_good_pushed", 32'(popped.size() - pop0), 32'd1);
`else
    check("parity_tied_low", 32'(pe_cnt), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
